inst_fetch_unit: RTL and testbench

//  Consumer side of the PC address interface: takes the PC's inst_addr, fetches
//  the word from instruction memory over a valid/ready request/response channel,
//  and presents {inst, pc, valid} to the IF/ID register. Drives the PC stall

---
 rtl/cpu_pkg.sv | 14 +
 rtl/inst_fetch_unit.sv | 102 ++++++++++
 tb/tb_inst_fetch_unit.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared fetch-side types and constants for the instruction fetch unit.
package cpu_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam logic [31:0] NOP_INST = 32'h0000_0000;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/inst_fetch_unit.sv
// Instruction fetch: issues PC to instruction memory (one outstanding fetch),
// registers the returned word for IF/ID and stalls the PC until its address is issued.
module inst_fetch_unit #(
  parameter int                 ADDR_W   = cpu_pkg::ADDR_W,
  parameter int                 DATA_W   = cpu_pkg::DATA_W,
  parameter logic [DATA_W-1:0]  NOP_INST = cpu_pkg::NOP_INST
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] pc_addr,
  input  logic              flush,
  output logic              stall_out,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_rsp_valid,
  output logic              imem_rsp_ready,
  input  logic [DATA_W-1:0] imem_rsp_data,
  input  logic              id_ready,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_inst,
  output logic [ADDR_W-1:0] if_pc
);

  import cpu_pkg::*;

  fetch_state_t      r_state;
  fetch_state_t      w_state_nxt;
  logic [ADDR_W-1:0] r_req_pc;
  logic              r_if_valid;
  logic [DATA_W-1:0] r_if_inst;
  logic [ADDR_W-1:0] r_if_pc;

  logic w_free;
  logic w_req_fire;
  logic w_rsp_fire;
  logic w_load;

  assign w_free     = ~r_if_valid | id_ready;
  assign w_req_fire = imem_req_valid & imem_req_ready;
  assign w_rsp_fire = imem_rsp_valid & imem_rsp_ready;
  // Only a response in WAIT carries a live instruction; DROP responses are stale.
  assign w_load     = (r_state == WAIT) & w_rsp_fire & ~flush;

  always_comb begin
    w_state_nxt    = r_state;
    imem_req_valid = 1'b0;
    imem_rsp_ready = 1'b0;
    case (r_state)
      REQ: begin
        imem_req_valid = ~flush;
        if (~flush & imem_req_ready) w_state_nxt = WAIT;
      end
      WAIT: begin
        imem_rsp_ready = w_free;
        if (imem_rsp_valid & w_free) w_state_nxt = REQ;
        else if (flush)              w_state_nxt = DROP;
      end
      DROP: begin
        imem_rsp_ready = 1'b1;
        if (imem_rsp_valid) w_state_nxt = REQ;
      end
      default: w_state_nxt = REQ;
    endcase
  end

  // Redirect must never be blocked: the PC prioritises stall over its target.
  assign stall_out = ~w_req_fire & ~flush;
  assign imem_addr = pc_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= REQ;
      r_req_pc <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_req_fire) r_req_pc <= pc_addr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_if_valid <= 1'b0;
      r_if_inst  <= NOP_INST;
      r_if_pc    <= '0;
    end else if (flush) begin
      r_if_valid <= 1'b0;
      r_if_inst  <= NOP_INST;
    end else if (w_load) begin
      r_if_valid <= 1'b1;
      r_if_inst  <= imem_rsp_data;
      r_if_pc    <= r_req_pc;
    end else if (id_ready) begin
      r_if_valid <= 1'b0;
    end
  end

  assign if_valid = r_if_valid;
  assign if_inst  = r_if_inst;
  assign if_pc    = r_if_pc;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit: reset, streaming, backpressure, flush cases, PC hold.
module tb_inst_fetch_unit;

  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc_addr;
  logic        flush;
  logic        stall_out;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic        imem_rsp_ready;
  logic [31:0] imem_rsp_data;
  logic        id_ready;
  logic        if_valid;
  logic [31:0] if_inst;
  logic [31:0] if_pc;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  inst_fetch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pc_addr        (pc_addr),
    .flush          (flush),
    .stall_out      (stall_out),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_ready (imem_rsp_ready),
    .imem_rsp_data  (imem_rsp_data),
    .id_ready       (id_ready),
    .if_valid       (if_valid),
    .if_inst        (if_inst),
    .if_pc          (if_pc)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; pc_addr = 32'h0; flush = 1'b0; imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0; id_ready = 1'b1;
    #12;
    rst_n = 1'b1;
    step();
    // load one word, then go back into WAIT
    pc_addr = 32'h100; imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'h1111_1111; id_ready = 1'b0;
    step();
    imem_rsp_valid = 1'b0; pc_addr = 32'h104; imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    checks++; if (dut.r_state !== WAIT) begin errors++; $display("FAIL pre_reset_state got %0d want %0d", dut.r_state, WAIT); end
    checks++; if (if_valid !== 1'b1 || if_inst !== 32'h1111_1111) begin errors++; $display("FAIL pre_reset_load got v=%0b inst=%h want v=1 inst=11111111", if_valid, if_inst); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (dut.r_state !== REQ) begin errors++; $display("FAIL reset_state got %0d want %0d", dut.r_state, REQ); end
    checks++; if (if_valid !== 1'b0 || if_inst !== 32'h0 || if_pc !== 32'h0) begin errors++; $display("FAIL reset_outputs got v=%0b inst=%h pc=%h want 0/0/0", if_valid, if_inst, if_pc); end
    checks++; if (stall_out !== 1'b1 || imem_req_valid !== 1'b1) begin errors++; $display("FAIL reset_stall got stall=%0b reqv=%0b want 1/1", stall_out, imem_req_valid); end
    #3 rst_n = 1'b1;
    id_ready = 1'b1;
    step();
  endtask

  task automatic test_stream();
    logic [31:0] d [3];
    d[0] = 32'hD000_0000; d[1] = 32'hD111_1111; d[2] = 32'hD222_2222;
    id_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      pc_addr = 32'(4 * i); imem_req_ready = 1'b1; imem_rsp_valid = 1'b0;
      #1;
      checks++; if (stall_out !== 1'b0 || imem_req_valid !== 1'b1 || imem_addr !== 32'(4 * i)) begin errors++; $display("FAIL stream_req%0d got stall=%0b reqv=%0b addr=%h want 0/1/%h", i, stall_out, imem_req_valid, imem_addr, 4 * i); end
      step();
      imem_rsp_valid = 1'b1; imem_rsp_data = d[i];
      #1;
      checks++; if (stall_out !== 1'b1 || imem_rsp_ready !== 1'b1) begin errors++; $display("FAIL stream_wait%0d got stall=%0b rspr=%0b want 1/1", i, stall_out, imem_rsp_ready); end
      step();
      checks++; if (if_valid !== 1'b1 || if_pc !== 32'(4 * i) || if_inst !== d[i]) begin errors++; $display("FAIL stream_out%0d got v=%0b pc=%h inst=%h want 1/%h/%h", i, if_valid, if_pc, if_inst, 4 * i, d[i]); end
    end
    imem_rsp_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    id_ready = 1'b0; pc_addr = 32'hC; imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'hAAAA_5555;
    #1;
    checks++; if (imem_rsp_ready !== 1'b0 || stall_out !== 1'b1) begin errors++; $display("FAIL bp_blocked got rspr=%0b stall=%0b want 0/1", imem_rsp_ready, stall_out); end
    step(); step();
    checks++; if (if_valid !== 1'b1 || if_inst !== 32'hD222_2222 || dut.r_state !== WAIT) begin errors++; $display("FAIL bp_hold got v=%0b inst=%h st=%0d want 1/d2222222/%0d", if_valid, if_inst, dut.r_state, WAIT); end
    id_ready = 1'b1;
    #1;
    checks++; if (imem_rsp_ready !== 1'b1) begin errors++; $display("FAIL bp_release got rspr=%0b want 1", imem_rsp_ready); end
    step();
    checks++; if (if_valid !== 1'b1 || if_inst !== 32'hAAAA_5555 || if_pc !== 32'hC) begin errors++; $display("FAIL bp_load got v=%0b inst=%h pc=%h want 1/aaaa5555/c", if_valid, if_inst, if_pc); end
    imem_rsp_valid = 1'b0;
  endtask

  task automatic test_flush_wait();
    id_ready = 1'b1; pc_addr = 32'h10; imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0; flush = 1'b1;
    #1;
    checks++; if (stall_out !== 1'b0) begin errors++; $display("FAIL flush_stall got %0b want 0", stall_out); end
    step();
    flush = 1'b0; pc_addr = 32'h40; imem_req_ready = 1'b1;
    checks++; if (dut.r_state !== DROP || if_valid !== 1'b0 || if_inst !== 32'h0) begin errors++; $display("FAIL flush_drop got st=%0d v=%0b inst=%h want %0d/0/0", dut.r_state, if_valid, if_inst, DROP); end
    #1;
    checks++; if (imem_req_valid !== 1'b0 || stall_out !== 1'b1) begin errors++; $display("FAIL drop_noreq got reqv=%0b stall=%0b want 0/1", imem_req_valid, stall_out); end
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEAD_BEEF;
    #1;
    checks++; if (imem_rsp_ready !== 1'b1) begin errors++; $display("FAIL drop_rspr got %0b want 1", imem_rsp_ready); end
    step();
    imem_rsp_valid = 1'b0;
    checks++; if (dut.r_state !== REQ || if_valid !== 1'b0 || if_inst !== 32'h0) begin errors++; $display("FAIL drop_discard got st=%0d v=%0b inst=%h want %0d/0/0", dut.r_state, if_valid, if_inst, REQ); end
    #1;
    checks++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h40) begin errors++; $display("FAIL redirect_req got reqv=%0b addr=%h want 1/40", imem_req_valid, imem_addr); end
    step();
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'h1234_5678;
    step();
    imem_rsp_valid = 1'b0;
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'h40 || if_inst !== 32'h1234_5678) begin errors++; $display("FAIL redirect_out got v=%0b pc=%h inst=%h want 1/40/12345678", if_valid, if_pc, if_inst); end
  endtask

  task automatic test_flush_rsp_same_cycle();
    id_ready = 1'b1; pc_addr = 32'h44; imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'hCAFE_F00D; flush = 1'b1;
    #1;
    checks++; if (stall_out !== 1'b0 || imem_rsp_ready !== 1'b1) begin errors++; $display("FAIL flushrsp_comb got stall=%0b rspr=%0b want 0/1", stall_out, imem_rsp_ready); end
    step();
    flush = 1'b0; imem_rsp_valid = 1'b0;
    checks++; if (dut.r_state !== REQ || if_valid !== 1'b0 || if_inst !== 32'h0) begin errors++; $display("FAIL flushrsp_out got st=%0d v=%0b inst=%h want %0d/0/0", dut.r_state, if_valid, if_inst, REQ); end
  endtask

  task automatic test_req_stall();
    pc_addr = 32'h80; imem_req_ready = 1'b0; id_ready = 1'b1;
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h5555_AAAA;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h80 || stall_out !== 1'b1) begin errors++; $display("FAIL hold%0d got reqv=%0b addr=%h stall=%0b want 1/80/1", i, imem_req_valid, imem_addr, stall_out); end
      step();
      checks++; if (dut.r_state !== REQ || if_valid !== 1'b0) begin errors++; $display("FAIL hold_state%0d got st=%0d v=%0b want %0d/0", i, dut.r_state, if_valid, REQ); end
    end
    imem_rsp_valid = 1'b0; imem_req_ready = 1'b1;
    #1;
    checks++; if (stall_out !== 1'b0) begin errors++; $display("FAIL hold_accept got stall=%0b want 0", stall_out); end
    step();
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0BAD_F00D;
    step();
    imem_rsp_valid = 1'b0;
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'h80 || if_inst !== 32'h0BAD_F00D) begin errors++; $display("FAIL hold_out got v=%0b pc=%h inst=%h want 1/80/0badf00d", if_valid, if_pc, if_inst); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_flush_wait();
    test_flush_rsp_same_cycle();
    test_req_stall();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
